// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder: master is the producer/consumer side,
// slave is the adder.
interface pipelined_adder_if #(
    parameter int WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;

    modport master (
        output in_valid, a, b, c_in, sub, out_ready,
        input  in_ready, out_valid, sum, c_out, ovf
    );

    modport slave (
        input  in_valid, a, b, c_in, sub, out_ready,
        output in_ready, out_valid, sum, c_out, ovf
    );
endinterface

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder/subtractor, CHUNK bits per stage, valid/ready with bubble collapse.
// Define PIPELINED_ADDER_OVF_EN to build the signed-overflow output; otherwise ovf is tied low.
module pipelined_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    pipelined_adder_if.slave   bus
);
    localparam int CHUNK = WIDTH / STAGES;
    localparam int LAST  = STAGES - 1;

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] c_r;
    logic [WIDTH-1:0]  a_r [STAGES];
    logic [WIDTH-1:0]  b_r [STAGES];
    logic [WIDTH-1:0]  s_r [STAGES];

    logic [STAGES-1:0] rdy;
    logic [STAGES-1:0] up_v;
    logic [STAGES-1:0] up_c;
    logic [WIDTH-1:0]  up_a [STAGES];
    logic [WIDTH-1:0]  up_b [STAGES];
    logic [WIDTH-1:0]  up_s [STAGES];
    logic [WIDTH-1:0]  nxt_s [STAGES];
    logic [STAGES-1:0] nxt_c;

    // Stage 0 sees the raw operands (B pre-inverted for subtract); later stages see skew registers.
    always_comb begin
        up_v[0] = bus.in_valid;
        up_a[0] = bus.a;
        up_b[0] = bus.sub ? ~bus.b : bus.b;
        up_s[0] = '0;
        up_c[0] = bus.sub | bus.c_in;
        for (int unsigned k = 1; k < STAGES; k++) begin
            up_v[k] = v[k-1];
            up_a[k] = a_r[k-1];
            up_b[k] = b_r[k-1];
            up_s[k] = s_r[k-1];
            up_c[k] = c_r[k-1];
        end
    end

    always_comb begin
        logic [CHUNK:0] seg;
        for (int unsigned k = 0; k < STAGES; k++) begin
            seg = {1'b0, up_a[k][k*CHUNK +: CHUNK]}
                + {1'b0, up_b[k][k*CHUNK +: CHUNK]}
                + (CHUNK+1)'(up_c[k]);
            nxt_s[k] = up_s[k];
            nxt_s[k][k*CHUNK +: CHUNK] = seg[CHUNK-1:0];
            nxt_c[k] = seg[CHUNK];
        end
    end

    // A stage may load when it is empty or everything downstream of it can advance.
    always_comb begin
        logic chain;
        rdy   = '0;
        chain = bus.out_ready | ~v[LAST];
        for (int unsigned i = 0; i < STAGES; i++) begin
            chain = chain | ~v[LAST - i];
            rdy[LAST - i] = chain;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v   <= '0;
            c_r <= '0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_r[k] <= '0;
                b_r[k] <= '0;
                s_r[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                if (rdy[k]) begin
                    v[k] <= up_v[k];
                    if (up_v[k]) begin
                        a_r[k] <= up_a[k];
                        b_r[k] <= up_b[k];
                        s_r[k] <= nxt_s[k];
                        c_r[k] <= nxt_c[k];
                    end
                end
            end
        end
    end

    assign bus.in_ready  = rdy[0];
    assign bus.out_valid = v[LAST];
    assign bus.sum       = s_r[LAST];
    assign bus.c_out     = c_r[LAST];

`ifdef PIPELINED_ADDER_OVF_EN
    logic msb_cin;
    logic c_msb_r;

    // Carry into the MSB recovered from its sum bit: s = a ^ b ^ cin.
    assign msb_cin = up_a[LAST][WIDTH-1] ^ up_b[LAST][WIDTH-1] ^ nxt_s[LAST][WIDTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_msb_r <= 1'b0;
        end else if (rdy[LAST] && up_v[LAST]) begin
            c_msb_r <= msb_cin;
        end
    end

    assign bus.ovf = c_msb_r ^ c_r[LAST];
`else
    assign bus.ovf = 1'b0;
`endif
endmodule
